// File: rtl/arbiter_matrix_pkt.sv
// Matrix (least-recently-served) arbiter with packet locking.
// A multi-flit winner holds the output until its tail is accepted.
module arbiter_matrix_pkt #(
  parameter int NUM_REQS = 3,
  localparam int ID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic [NUM_REQS-1:0] tails,
  input  logic                ready,
  output logic [NUM_REQS-1:0] grants,
  output logic                grant_valid,
  output logic [ID_W-1:0]     grant_id,
  output logic                locked,
  output logic [ID_W-1:0]     owner_id
);

  logic                r_locked;
  logic [ID_W-1:0]     r_owner;
  logic [NUM_REQS-1:0] w_unl;
  logic [NUM_REQS-1:0] w_lck;
  logic [NUM_REQS-1:0] w_gnt;
  logic [ID_W-1:0]     w_gid;
  logic                w_accept;
  logic                w_tail;
  logic                w_upd;
  logic [NUM_REQS-1:0] w_msk [ID_W];

  generate
    if (NUM_REQS == 1) begin : g_one
      assign w_unl = requests;
    end else begin : g_mat
      localparam int TRI = NUM_REQS * (NUM_REQS - 1) / 2;
      // r_tri holds w[a][b] for a<b; the lower half is its complement.
      logic [TRI-1:0]      r_tri;
      logic [TRI-1:0]      w_nxt;
      logic [NUM_REQS-1:0] w_col [NUM_REQS];

      for (genvar i = 0; i < NUM_REQS; i++) begin : g_i
        for (genvar j = 0; j < NUM_REQS; j++) begin : g_j
          if (j < i) begin : g_lo
            localparam int K = j*NUM_REQS - (j*(j+1))/2 + (i-j-1);
            assign w_col[i][j] = r_tri[K];
          end else if (j > i) begin : g_hi
            localparam int K = i*NUM_REQS - (i*(i+1))/2 + (j-i-1);
            assign w_col[i][j] = ~r_tri[K];
            assign w_nxt[K] = w_gnt[j] ? 1'b1 :
                              w_gnt[i] ? 1'b0 : r_tri[K];
          end else begin : g_dg
            assign w_col[i][j] = 1'b0;
          end
        end
        assign w_unl[i] = requests[i] & ~|(requests & w_col[i]);
      end

      // Winner of a completed packet drops to lowest priority.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tri <= '1;
        end else if (w_upd) begin
          r_tri <= w_nxt;
        end
      end
    end
  endgenerate

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lck
    assign w_lck[i] = requests[i] & (r_owner == ID_W'(i));
  end

  for (genvar k = 0; k < ID_W; k++) begin : g_id
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_m
      assign w_msk[k][i] = ((i >> k) & 1) == 1;
    end
    assign w_gid[k] = |(w_gnt & w_msk[k]);
  end

  // Grant source: owner while locked, matrix otherwise; gated by reset.
  always_comb begin
    w_gnt = '0;
    if (reset) begin
      w_gnt = r_locked ? w_lck : w_unl;
    end
  end

  assign w_accept = (|w_gnt) & ready;
  assign w_tail   = |(w_gnt & tails);
  assign w_upd    = w_accept & w_tail;

  // Lock on an accepted non-tail flit, release on an accepted tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (w_accept) begin
      if (w_tail) begin
        r_locked <= 1'b0;
        r_owner  <= '0;
      end else begin
        r_locked <= 1'b1;
        r_owner  <= w_gid;
      end
    end
  end

  assign grants      = w_gnt;
  assign grant_valid = |w_gnt;
  assign grant_id    = w_gid;
  assign locked      = r_locked;
  assign owner_id    = r_owner;

  a_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grants));
  a_subset: assert property (@(posedge clk) disable iff (!reset)
    (grants & ~requests) == '0);
  a_owner: assert property (@(posedge clk) disable iff (!reset)
    !locked |-> owner_id == '0);

endmodule
